// File: rtl/cacheline_adapter.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory port: 4-beat writes, 4-beat read assembly.
// Optional macro CACHELINE_ADAPTER_RADDR_CHECK_EN drops mis-tagged read beats and raises a sticky err.
module cacheline_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              err
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int KW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_COLLECT,
        WR_BURST,
        DONE,
        DRAIN
    } state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [KW-1:0]     k_nxt;
    logic [LINE_W-1:0] buffer;
    logic [LINE_W-1:0] line_nxt;
    logic [31:0]       line_addr;
    logic              beat_ok;
    logic              unused_addr_lsb;

    assign k_nxt           = k + KW'(1);
    assign line_addr       = {dfp_addr[31:5], 5'b0};
    assign unused_addr_lsb = ^dfp_addr[4:0];

    // Buffer with the incoming beat merged in, so the final beat can go straight to dfp_rdata.
    always_comb begin
        line_nxt = buffer;
        line_nxt[int'(k)*BEAT_W +: BEAT_W] = bmem_rdata;
    end

`ifdef CACHELINE_ADAPTER_RADDR_CHECK_EN
    logic stray;

    assign beat_ok = (bmem_raddr == bmem_addr);
    // IDLE is exempt so beats still in flight after a mid-burst reset are tolerated.
    assign stray   = bmem_rvalid && (state != IDLE) && (state != RD_COLLECT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (stray || (state == RD_COLLECT && bmem_rvalid && !beat_ok)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_raddr;

    assign beat_ok      = 1'b1;
    assign unused_raddr = ^bmem_raddr;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            k          <= '0;
            buffer     <= '0;
            dfp_rdata  <= '0;
            dfp_resp   <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dfp_write) begin
                        bmem_addr  <= line_addr;
                        buffer     <= dfp_wdata;
                        k          <= '0;
                        bmem_write <= 1'b1;
                        bmem_wdata <= dfp_wdata[BEAT_W-1:0];
                        state      <= WR_BURST;
                    end else if (dfp_read) begin
                        bmem_addr <= line_addr;
                        bmem_read <= 1'b1;
                        k         <= '0;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        k         <= '0;
                        state     <= RD_COLLECT;
                    end
                end
                RD_COLLECT: begin
                    if (bmem_rvalid && beat_ok) begin
                        buffer <= line_nxt;
                        k      <= k_nxt;
                        if (k == K_LAST) begin
                            dfp_rdata <= line_nxt;
                            dfp_resp  <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        k <= k_nxt;
                        if (k == K_LAST) begin
                            bmem_write <= 1'b0;
                            bmem_wdata <= '0;
                            dfp_resp   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            bmem_wdata <= buffer[int'(k_nxt)*BEAT_W +: BEAT_W];
                        end
                    end
                end
                DONE: begin
                    dfp_resp <= 1'b0;
                    state    <= DRAIN;
                end
                DRAIN: begin
                    // A request still held after the response must not start a second burst.
                    if (!dfp_read && !dfp_write) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
